// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan generator for the sprite renderers.
// Produces pixel coordinates, display enable, active-low syncs, a frame-start
// strobe and a running-animation frame index. Every output is registered and
// all outputs in a given cycle describe the same (DrawX, DrawY) position.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ANIM_DIV    = 6,
    parameter int ANIM_FRAMES = 3
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       anim_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [1:0] anim_frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Divider is at least one bit wide so ANIM_DIV=1 still elaborates cleanly.
    localparam int              DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);
    localparam logic [1:0]       FRAME_LAST = 2'(ANIM_FRAMES - 1);

    // h_cnt/v_cnt hold the position that will be presented on the next edge.
    // Keeping them one step ahead of DrawX/DrawY lets every output be decoded
    // from the same counter value and registered together.
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             blank_d;
    logic             hs_d;
    logic             vs_d;
    logic             frame_start_d;
    logic [DIV_W-1:0] divider;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Advance the look-ahead scan position; both counters wrap on the same edge.
    always_ff @(posedge vga_clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples values from before the edge, independent of statement order.
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Decode display enable, syncs and frame start for the look-ahead position.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no
        // latch is inferred.
        blank_d       = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_d          = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
        vs_d          = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
        frame_start_d = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // Register the coordinates together with their decoded timing flags.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= h_cnt;
            DrawY       <= v_cnt;
            blank       <= blank_d;
            hs          <= hs_d;
            vs          <= vs_d;
            frame_start <= frame_start_d;
        end
    end

    // Step the animation once per ANIM_DIV enabled frames, only at frame start,
    // so anim_frame is stable across the frame that follows.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            divider    <= '0;
            anim_frame <= '0;
        end else if (frame_start && anim_en) begin
            if (divider == DIV_LAST) begin
                divider    <= '0;
                anim_frame <= (anim_frame == FRAME_LAST) ? 2'd0 : anim_frame + 2'd1;
            end else begin
                divider <= divider + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen against a position-arithmetic model.
// One instance uses the default 640x480 timing; three use a compact raster
// (15 clocks x 8 lines) with different animation settings so whole frames,
// animation wrap and the ANIM_DIV=1 / ANIM_FRAMES=1 corners fit in a short run.
module tb_vga_timing_gen;

    localparam int N = 4;
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;

    logic vga_clk = 1'b0;
    logic reset;
    logic anim_en;

    always #5 vga_clk = ~vga_clk;

    logic [9:0] dx [N];
    logic [9:0] dy [N];
    logic       bl [N];
    logic       hs [N];
    logic       vs [N];
    logic       fs [N];
    logic [1:0] af [N];

    vga_timing_gen u_def (
        .vga_clk(vga_clk), .reset(reset), .anim_en(anim_en),
        .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]), .hs(hs[0]), .vs(vs[0]),
        .frame_start(fs[0]), .anim_frame(af[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .ANIM_DIV(6), .ANIM_FRAMES(3)
    ) u_a (
        .vga_clk(vga_clk), .reset(reset), .anim_en(anim_en),
        .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]), .hs(hs[1]), .vs(vs[1]),
        .frame_start(fs[1]), .anim_frame(af[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .ANIM_DIV(1), .ANIM_FRAMES(4)
    ) u_b (
        .vga_clk(vga_clk), .reset(reset), .anim_en(anim_en),
        .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]), .hs(hs[2]), .vs(vs[2]),
        .frame_start(fs[2]), .anim_frame(af[2])
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .ANIM_DIV(2), .ANIM_FRAMES(1)
    ) u_c (
        .vga_clk(vga_clk), .reset(reset), .anim_en(anim_en),
        .DrawX(dx[3]), .DrawY(dy[3]), .blank(bl[3]), .hs(hs[3]), .vs(vs[3]),
        .frame_start(fs[3]), .anim_frame(af[3])
    );

    // Per-instance timing description used by the model.
    int p_hv [N];
    int p_vv [N];
    int p_ht [N];
    int p_vt [N];
    int p_hs0[N];
    int p_hs1[N];
    int p_vs0[N];
    int p_vs1[N];
    int p_div[N];
    int p_fr [N];

    // Model state and expectations.
    int   t;            // cycles since reset release; position index is t-1
    int   cyc;
    int   n_en [N];     // frame starts so far that saw anim_en=1
    logic prev_fs [N];
    int   e_x [N];
    int   e_y [N];
    int   e_bl[N];
    int   e_hs[N];
    int   e_vs[N];
    int   e_fs[N];
    int   e_af[N];
    logic started;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d] cyc %0d: got %0d expected %0d",
                     name, idx, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 20000) begin
            @(negedge vga_clk);
            guard++;
        end
        check("wait_cyc", 0, 32'(cyc), 32'(c));
    endtask

    task automatic lit_pos(input int i, input int x, input int y);
        check("lit_DrawX", i, 32'(dx[i]), 32'(x));
        check("lit_DrawY", i, 32'(dy[i]), 32'(y));
    endtask

    initial begin
        p_hv  = '{640, SHV, SHV, SHV};
        p_vv  = '{480, SVV, SVV, SVV};
        p_ht  = '{800, 15, 15, 15};
        p_vt  = '{525, 8, 8, 8};
        p_hs0 = '{656, 10, 10, 10};
        p_hs1 = '{752, 13, 13, 13};
        p_vs0 = '{490, 5, 5, 5};
        p_vs1 = '{492, 7, 7, 7};
        p_div = '{6, 6, 1, 2};
        p_fr  = '{3, 3, 4, 1};
    end

    // Model: expected outputs are pure arithmetic on the position index and on
    // the number of enabled frame starts; compared #1 after every rising edge.
    initial begin
        int p, x, y;
        started = 1'b0;
        t = 0;
        cyc = 0;
        forever begin
            @(posedge vga_clk);
            if (reset) begin
                started = 1'b1;
                t = 0;
                for (int i = 0; i < N; i++) begin
                    n_en[i] = 0;  prev_fs[i] = 1'b0;
                    e_x[i] = 0;   e_y[i] = 0;   e_bl[i] = 0;
                    e_hs[i] = 1;  e_vs[i] = 1;  e_fs[i] = 0;  e_af[i] = 0;
                end
            end else if (started) begin
                t++;
                for (int i = 0; i < N; i++) begin
                    if (prev_fs[i] && anim_en) n_en[i]++;
                    p = (t - 1) % (p_ht[i] * p_vt[i]);
                    x = p % p_ht[i];
                    y = p / p_ht[i];
                    e_x[i]  = x;
                    e_y[i]  = y;
                    e_bl[i] = (x < p_hv[i] && y < p_vv[i]) ? 1 : 0;
                    e_hs[i] = (x >= p_hs0[i] && x < p_hs1[i]) ? 0 : 1;
                    e_vs[i] = (y >= p_vs0[i] && y < p_vs1[i]) ? 0 : 1;
                    e_fs[i] = (p == 0) ? 1 : 0;
                    e_af[i] = (n_en[i] / p_div[i]) % p_fr[i];
                    prev_fs[i] = (p == 0);
                end
            end
            cyc = t;
            if (started) begin
                #1;
                for (int i = 0; i < N; i++) begin
                    check("DrawX",       i, 32'(dx[i]), 32'(e_x[i]));
                    check("DrawY",       i, 32'(dy[i]), 32'(e_y[i]));
                    check("blank",       i, 32'(bl[i]), 32'(e_bl[i]));
                    check("hs",          i, 32'(hs[i]), 32'(e_hs[i]));
                    check("vs",          i, 32'(vs[i]), 32'(e_vs[i]));
                    check("frame_start", i, 32'(fs[i]), 32'(e_fs[i]));
                    check("anim_frame",  i, 32'(af[i]), 32'(e_af[i]));
                end
            end
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        reset   = 1'b1;
        anim_en = 1'b1;
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;

        // First cycle after release: origin, visible, frame start.
        wait_cyc(1);
        lit_pos(0, 0, 0);
        check("lit_blank", 0, 32'(bl[0]), 32'd1);
        check("lit_fs",    0, 32'(fs[0]), 32'd1);
        check("lit_hs",    0, 32'(hs[0]), 32'd1);
        check("lit_vs",    0, 32'(vs[0]), 32'd1);
        lit_pos(1, 0, 0);
        check("lit_fs",    1, 32'(fs[1]), 32'd1);

        // Compact raster: vsync on lines 5..6 only.
        wait_cyc(75);   lit_pos(1, 14, 4);  check("lit_vs", 1, 32'(vs[1]), 32'd1);
        wait_cyc(76);   lit_pos(1, 0, 5);   check("lit_vs", 1, 32'(vs[1]), 32'd0);
        check("lit_blank", 1, 32'(bl[1]), 32'd0);
        wait_cyc(106);  lit_pos(1, 0, 7);   check("lit_vs", 1, 32'(vs[1]), 32'd1);
        wait_cyc(120);  lit_pos(1, 14, 7);  check("lit_fs", 1, 32'(fs[1]), 32'd0);
        wait_cyc(121);  lit_pos(1, 0, 0);   check("lit_fs", 1, 32'(fs[1]), 32'd1);
        check("lit_anim", 2, 32'(af[2]), 32'd1);
        wait_cyc(361);  check("lit_anim", 2, 32'(af[2]), 32'd3);
        wait_cyc(481);  check("lit_anim", 2, 32'(af[2]), 32'd0);
        wait_cyc(601);  check("lit_anim", 1, 32'(af[1]), 32'd0);

        // Default raster: blank, hsync edges and line wrap.
        wait_cyc(641);  lit_pos(0, 640, 0); check("lit_blank", 0, 32'(bl[0]), 32'd0);
        wait_cyc(656);  lit_pos(0, 655, 0); check("lit_hs", 0, 32'(hs[0]), 32'd1);
        wait_cyc(657);  lit_pos(0, 656, 0); check("lit_hs", 0, 32'(hs[0]), 32'd0);
        wait_cyc(721);  check("lit_anim", 1, 32'(af[1]), 32'd1);
        wait_cyc(752);  lit_pos(0, 751, 0); check("lit_hs", 0, 32'(hs[0]), 32'd0);
        wait_cyc(753);  lit_pos(0, 752, 0); check("lit_hs", 0, 32'(hs[0]), 32'd1);
        wait_cyc(800);  lit_pos(0, 799, 0);
        wait_cyc(801);  lit_pos(0, 0, 1);   check("lit_fs", 0, 32'(fs[0]), 32'd0);

        // Animation cycle wraps back to 0 at frame 18.
        wait_cyc(2041); check("lit_anim", 1, 32'(af[1]), 32'd2);
        wait_cyc(2161); check("lit_anim", 1, 32'(af[1]), 32'd0);
        wait_cyc(2881); check("lit_anim", 1, 32'(af[1]), 32'd1);

        // Hold animation for ten frames, then re-enable.
        wait_cyc(2890); anim_en = 1'b0;
        wait_cyc(4081); check("lit_anim", 1, 32'(af[1]), 32'd1);
        check("lit_fs", 1, 32'(fs[1]), 32'd1);
        wait_cyc(4090); anim_en = 1'b1;
        wait_cyc(4681); check("lit_anim", 1, 32'(af[1]), 32'd1);
        wait_cyc(4801); check("lit_anim", 1, 32'(af[1]), 32'd2);
        check("lit_anim", 3, 32'(af[3]), 32'd0);

        // Mid-frame reset aborts the scan.
        wait_cyc(4836); lit_pos(1, 5, 2);
        reset = 1'b1;
        @(negedge vga_clk);
        lit_pos(1, 0, 0);
        check("lit_rst_blank", 1, 32'(bl[1]), 32'd0);
        check("lit_rst_hs",    1, 32'(hs[1]), 32'd1);
        check("lit_rst_vs",    1, 32'(vs[1]), 32'd1);
        check("lit_rst_anim",  1, 32'(af[1]), 32'd0);
        check("lit_rst_fs",    1, 32'(fs[1]), 32'd0);
        @(negedge vga_clk);
        reset = 1'b0;
        wait_cyc(1);
        lit_pos(1, 0, 0);
        check("lit_blank", 1, 32'(bl[1]), 32'd1);
        check("lit_fs",    1, 32'(fs[1]), 32'd1);
        wait_cyc(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
